// File: rtl/load_store_unit.sv
// Load/store unit: initiator side of the byte-lane data memory port.
// Splits misaligned accesses into two aligned words and extends load data.
module load_store_unit #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter bit          SPLIT_EN   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic                  mem_re,
  output logic [3:0]            mem_byte_sel,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);

  localparam int unsigned WW = ADDR_WIDTH - 2;

  typedef enum logic [1:0] {
    IDLE,
    ACC0,
    ACC1,
    RESP
  } state_e;

  state_e                state_q;
  logic                  we_q;
  logic [2:0]            f3_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [31:0]           rd0_q;

  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic                  mem_we_q;
  logic                  mem_re_q;
  logic [3:0]            sel_q;
  logic [31:0]           mem_wdata_q;
  logic                  resp_valid_q;
  logic                  resp_err_q;
  logic [31:0]           resp_rdata_q;

  logic [1:0]            o_q;
  logic [4:0]            sh_q;
  logic [5:0]            shr_q;
  logic [WW-1:0]         widx_nxt;
  logic [31:0]           raw_one;
  logic [31:0]           raw_two;
  logic                  unused_addr;

  function automatic logic legal(input logic [2:0] f3);
    return f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
  endfunction

  function automatic logic [2:0] size_of(input logic [2:0] f3);
    logic [2:0] s;
    unique case (1'b1)
      f3[1:0] == 2'b00: s = 3'd1;
      f3[1:0] == 2'b01: s = 3'd2;
      default:          s = 3'd4;
    endcase
    return s;
  endfunction

  function automatic logic [3:0] mask_of(input logic [2:0] f3);
    logic [3:0] m;
    unique case (1'b1)
      f3[1:0] == 2'b00: m = 4'b0001;
      f3[1:0] == 2'b01: m = 4'b0011;
      default:          m = 4'b1111;
    endcase
    return m;
  endfunction

  function automatic logic misal(
    input logic [2:0] f3,
    input logic [1:0] o
  );
    return (f3[1:0] == 2'b01 && o[0])
        || (f3[1:0] == 2'b10 && o != 2'b00);
  endfunction

  function automatic logic split_of(
    input logic [2:0] f3,
    input logic [1:0] o
  );
    return ({1'b0, o} + size_of(f3)) > 3'd4;
  endfunction

  function automatic logic [31:0] ext(
    input logic [2:0]  f3,
    input logic [31:0] raw
  );
    logic [31:0] r;
    unique case (f3)
      3'b000:  r = {{24{raw[7]}}, raw[7:0]};
      3'b100:  r = {24'h0, raw[7:0]};
      3'b001:  r = {{16{raw[15]}}, raw[15:0]};
      3'b101:  r = {16'h0, raw[15:0]};
      default: r = raw;
    endcase
    return r;
  endfunction

  assign o_q      = addr_q[1:0];
  assign sh_q     = {o_q, 3'b000};
  assign shr_q    = 6'd32 - {1'b0, sh_q};
  assign widx_nxt = addr_q[ADDR_WIDTH-1:2] + WW'(1);

  // Split loads always have o != 0, so the upper shift stays below 32.
  assign raw_one  = mem_rdata >> sh_q;
  assign raw_two  = (rd0_q >> sh_q) | (mem_rdata << shr_q);

  assign unused_addr = ^req_addr[31:ADDR_WIDTH];

  assign req_ready    = (state_q == IDLE);
  assign resp_valid   = resp_valid_q;
  assign resp_rdata   = resp_rdata_q;
  assign resp_err     = resp_err_q;
  assign mem_addr     = mem_addr_q;
  assign mem_we       = mem_we_q;
  assign mem_re       = mem_re_q;
  assign mem_byte_sel = sel_q;
  assign mem_wdata    = mem_wdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      f3_q         <= 3'b000;
      addr_q       <= '0;
      wdata_q      <= 32'h0;
      rd0_q        <= 32'h0;
      mem_addr_q   <= '0;
      mem_we_q     <= 1'b0;
      mem_re_q     <= 1'b0;
      sel_q        <= 4'h0;
      mem_wdata_q  <= 32'h0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            f3_q    <= req_funct3;
            addr_q  <= req_addr[ADDR_WIDTH-1:0];
            wdata_q <= req_wdata;
            rd0_q   <= 32'h0;
            if (!legal(req_funct3) ||
                (!SPLIT_EN && misal(req_funct3, req_addr[1:0]))) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= 32'h0;
            end else begin
              state_q     <= ACC0;
              mem_addr_q  <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
              mem_we_q    <= req_we;
              mem_re_q    <= !req_we;
              sel_q       <= mask_of(req_funct3) << req_addr[1:0];
              mem_wdata_q <= req_wdata << {req_addr[1:0], 3'b000};
            end
          end
        end
        ACC0: begin
          if (split_of(f3_q, o_q)) begin
            state_q     <= ACC1;
            rd0_q       <= mem_rdata;
            mem_addr_q  <= {widx_nxt, 2'b00};
            sel_q       <= mask_of(f3_q) >> (3'd4 - {1'b0, o_q});
            mem_wdata_q <= wdata_q >> shr_q;
          end else begin
            state_q      <= RESP;
            mem_we_q     <= 1'b0;
            mem_re_q     <= 1'b0;
            sel_q        <= 4'h0;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= we_q ? 32'h0 : ext(f3_q, raw_one);
          end
        end
        ACC1: begin
          state_q      <= RESP;
          mem_we_q     <= 1'b0;
          mem_re_q     <= 1'b0;
          sel_q        <= 4'h0;
          resp_valid_q <= 1'b1;
          resp_rdata_q <= we_q ? 32'h0 : ext(f3_q, raw_two);
        end
        RESP: begin
          state_q      <= IDLE;
          resp_valid_q <= 1'b0;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= 32'h0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-array reference memory model,
// directed and random requests, split-disabled instance, mid-op reset.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [7:0]  mem_addr;
  logic        mem_we, mem_re;
  logic [3:0]  mem_byte_sel;
  logic [31:0] mem_wdata, mem_rdata;

  logic        ns_valid, ns_ready, ns_we;
  logic [2:0]  ns_funct3;
  logic [31:0] ns_addr, ns_wdata;
  logic        ns_rvalid, ns_err;
  logic [31:0] ns_rdata;
  logic [7:0]  ns_maddr;
  logic        ns_mwe, ns_mre;
  logic [3:0]  ns_sel;
  logic [31:0] ns_mwdata;
  logic [31:0] ns_mrdata = 32'h0;

  int n_chk  = 0;
  int n_pass = 0;

  bit [7:0]    ref_mem [256];
  logic [31:0] mem_w [64];
  bit          mem_init = 1'b0;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_WIDTH(8), .SPLIT_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_re(mem_re),
    .mem_byte_sel(mem_byte_sel), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  load_store_unit #(.ADDR_WIDTH(8), .SPLIT_EN(1'b0)) u_ns (
    .clk(clk), .rst_n(rst_n),
    .req_valid(ns_valid), .req_ready(ns_ready),
    .req_we(ns_we), .req_funct3(ns_funct3),
    .req_addr(ns_addr), .req_wdata(ns_wdata),
    .resp_valid(ns_rvalid), .resp_rdata(ns_rdata),
    .resp_err(ns_err),
    .mem_addr(ns_maddr), .mem_we(ns_mwe), .mem_re(ns_mre),
    .mem_byte_sel(ns_sel), .mem_wdata(ns_mwdata),
    .mem_rdata(ns_mrdata)
  );

  // Word memory: writes on negedge, reads combinational on selected lanes.
  always @(negedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++)
        mem_w[i] <= {ref_mem[4*i+3], ref_mem[4*i+2],
                     ref_mem[4*i+1], ref_mem[4*i]};
    end else if (mem_we) begin
      for (int j = 0; j < 4; j++)
        if (mem_byte_sel[j])
          mem_w[mem_addr[7:2]][8*j +: 8] <= mem_wdata[8*j +: 8];
    end
  end

  always_comb begin
    mem_rdata = 32'h0;
    if (mem_re)
      for (int j = 0; j < 4; j++)
        if (mem_byte_sel[j])
          mem_rdata[8*j +: 8] = mem_w[mem_addr[7:2]][8*j +: 8];
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic do_req(input bit we, input bit [2:0] f3,
                        input bit [31:0] addr, input bit [31:0] wd);
    int          a, o, sz, nacc_x, lat_x, nacc, lat;
    bit          lgl, err_x;
    bit [31:0]   rd_x, wd_x;
    bit [3:0]    sel_x;
    int          w;
    logic [7:0]  oa [2];
    logic [3:0]  os [2];
    logic [31:0] ow [2];
    logic [1:0]  owr [2];
    logic [31:0] g_rd;
    logic        g_err;

    a      = int'(addr[7:0]);
    o      = a % 4;
    sz     = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    lgl    = (f3 == 0) || (f3 == 1) || (f3 == 2) || (f3 == 4) || (f3 == 5);
    err_x  = !lgl;
    nacc_x = !lgl ? 0 : ((o + sz > 4) ? 2 : 1);
    lat_x  = nacc_x + 1;
    rd_x   = 0;
    if (lgl && we) begin
      for (int i = 0; i < sz; i++)
        ref_mem[(a + i) % 256] = wd[8*i +: 8];
    end else if (lgl) begin
      for (int i = 0; i < sz; i++)
        rd_x = rd_x | ({24'h0, ref_mem[(a + i) % 256]} << (8 * i));
      if (f3 == 0 && rd_x[7])  rd_x = rd_x | 32'hFFFF_FF00;
      if (f3 == 1 && rd_x[15]) rd_x = rd_x | 32'hFFFF_0000;
    end

    @(negedge clk);
    chk("ready", {31'h0, req_ready}, 32'h1);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    @(posedge clk);
    #1;
    req_valid  = $urandom_range(0, 1) == 1;
    req_we     = 1'($urandom);
    req_funct3 = 3'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;

    nacc = 0; lat = -1; g_rd = 'x; g_err = 'x;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (mem_we || mem_re) begin
        if (nacc < 2) begin
          oa[nacc]  = mem_addr;
          os[nacc]  = mem_byte_sel;
          ow[nacc]  = mem_wdata;
          owr[nacc] = {mem_we, mem_re};
        end
        nacc++;
      end
      if (resp_valid) begin
        lat = c; g_rd = resp_rdata; g_err = resp_err;
        break;
      end
    end
    req_valid = 1'b0;

    chk("latency", lat, lat_x);
    chk("resp_err", {31'h0, g_err}, {31'h0, err_x});
    chk("resp_rdata", g_rd, rd_x);
    chk("n_access", nacc, nacc_x);
    for (int k = 0; k < 2; k++) begin
      if (k < nacc && k < nacc_x) begin
        w = ((a / 4) + k) % 64;
        sel_x = 4'h0;
        for (int j = 0; j < 4; j++)
          for (int i = 0; i < sz; i++)
            if ((a + i) % 256 == w * 4 + j) sel_x[j] = 1'b1;
        chk("mem_addr", {24'h0, oa[k]}, w * 4);
        chk("byte_sel", {28'h0, os[k]}, {28'h0, sel_x});
        chk("we_re", {30'h0, owr[k]}, {30'h0, we, !we});
        if (we) begin
          wd_x = (k == 0) ? (wd << (8 * o)) : (wd >> (8 * (4 - o)));
          chk("mem_wdata", ow[k], wd_x);
        end
      end
    end
  endtask

  task automatic ns_req(input bit [2:0] f3, input bit [31:0] addr);
    int   o, sz, nacc, lat;
    bit   lgl, err_x;
    logic g_err;
    logic [31:0] g_rd;
    o     = int'(addr[1:0]);
    sz    = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    lgl   = (f3 == 0) || (f3 == 1) || (f3 == 2) || (f3 == 4) || (f3 == 5);
    err_x = !lgl || (o % sz != 0);
    @(negedge clk);
    ns_valid = 1'b1; ns_we = 1'b0; ns_funct3 = f3;
    ns_addr = addr; ns_wdata = 32'h0;
    @(posedge clk);
    #1 ns_valid = 1'b0;
    nacc = 0; lat = -1; g_err = 'x; g_rd = 'x;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (ns_mwe || ns_mre) nacc++;
      if (ns_rvalid) begin
        lat = c; g_err = ns_err; g_rd = ns_rdata;
        break;
      end
    end
    chk("ns_latency", lat, err_x ? 1 : 2);
    chk("ns_err", {31'h0, g_err}, {31'h0, err_x});
    chk("ns_access", nacc, err_x ? 0 : 1);
    chk("ns_rdata", g_rd, 32'h0);
  endtask

  task automatic reset_mid_split();
    bit [31:0] wd;
    wd = 32'hCAFE_F00D;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h0000_000D; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1 chk("split_acc1_sel", {28'h0, mem_byte_sel}, 32'h1);
    #1 rst_n = 1'b0;
    #1;
    chk("mr_we_re_sel", {26'h0, mem_we, mem_re, mem_byte_sel}, 32'h0);
    chk("mr_resp", {30'h0, resp_valid, resp_err}, 32'h0);
    chk("mr_ready", {31'h0, req_ready}, 32'h1);
    chk("mr_addr", {24'h0, mem_addr}, 32'h0);
    chk("mr_wdata", mem_wdata, 32'h0);
    for (int i = 0; i < 3; i++) ref_mem[13 + i] = wd[8*i +: 8];
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    bit [31:0] r;
    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    ns_valid = 1'b0; ns_we = 1'b0; ns_funct3 = 3'b0;
    ns_addr = 32'h0; ns_wdata = 32'h0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'($urandom);
    mem_init = 1'b1;
    @(negedge clk);
    #1 mem_init = 1'b0;
    chk("rst_ctrl", {23'h0, mem_we, mem_re, mem_byte_sel,
                     resp_valid, resp_err, req_ready}, 32'h1);
    chk("rst_addr", {24'h0, mem_addr}, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_rdata", resp_rdata, 32'h0);
    @(negedge clk);
    #2 rst_n = 1'b1;

    do_req(1, 3'b010, 32'h10, 32'hDEAD_BEEF);
    do_req(0, 3'b010, 32'h10, 32'h0);
    do_req(1, 3'b000, 32'h13, 32'h0000_00A5);
    do_req(0, 3'b000, 32'h13, 32'h0);
    do_req(0, 3'b100, 32'h13, 32'h0);
    do_req(1, 3'b001, 32'h22, 32'h0000_8001);
    do_req(0, 3'b001, 32'h22, 32'h0);
    do_req(0, 3'b101, 32'h22, 32'h0);
    do_req(1, 3'b010, 32'h05, 32'h1122_3344);
    do_req(0, 3'b010, 32'h05, 32'h0);
    do_req(0, 3'b001, 32'hFF, 32'h0);
    do_req(1, 3'b001, 32'hABCD_EF7F, 32'h0000_5AA5);
    do_req(0, 3'b011, 32'h10, 32'h0);
    do_req(1, 3'b110, 32'h11, 32'h1234_5678);

    reset_mid_split();
    do_req(0, 3'b010, 32'h0D, 32'h0);
    do_req(0, 3'b010, 32'h0C, 32'h0);

    for (int t = 0; t < 300; t++) begin
      r = $urandom;
      do_req(1'($urandom), 3'($urandom), r, $urandom);
    end

    ns_req(3'b010, 32'h02);
    ns_req(3'b001, 32'h01);
    ns_req(3'b001, 32'h02);
    ns_req(3'b000, 32'h03);
    ns_req(3'b011, 32'h04);
    ns_req(3'b010, 32'h08);

    @(negedge clk);
    for (int i = 0; i < 64; i++)
      chk("final_mem", mem_w[i], {ref_mem[4*i+3], ref_mem[4*i+2],
                                  ref_mem[4*i+1], ref_mem[4*i]});

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
